// File: rtl/ks_adder_pkg.sv
// Shared definitions for the sequential multi-precision adder: FSM encoding
// and helpers for sizing the word index.
package ks_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ks_state_e;

  localparam int KS_ADDER_W = 64;

  // Word index width; never below one bit so the index register always exists.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/ks_adder_64.sv
// Kogge-Stone parallel-prefix adder, one word wide, with carry in/out.
// Carry-in is folded into bit 0's generate so the prefix tree yields all carries.
module ks_adder_64 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int LVL = $clog2(WIDTH);

  logic [WIDTH-1:0] p_bit;
  logic [WIDTH-1:0] g_lvl [LVL+1];
  logic [WIDTH-1:0] p_lvl [LVL+1];

  assign p_bit = a_i ^ b_i;

  always_comb begin
    g_lvl[0]    = a_i & b_i;
    p_lvl[0]    = p_bit;
    g_lvl[0][0] = (a_i[0] & b_i[0]) | (p_bit[0] & cin_i);
    for (int l = 0; l < LVL; l++) begin
      // Shifted-in zeros leave already-resolved low bits untouched.
      g_lvl[l+1] = g_lvl[l] | (p_lvl[l] & (g_lvl[l] << (1 << l)));
      p_lvl[l+1] = p_lvl[l] & (p_lvl[l] << (1 << l));
    end
  end

  assign sum_o  = p_bit ^ {g_lvl[LVL][WIDTH-2:0], cin_i};
  assign cout_o = g_lvl[LVL][WIDTH-1];

endmodule

// File: rtl/ks_mpadd_seq.sv
// Sequential multi-precision adder: one word per cycle through a single
// Kogge-Stone adder. Define KS_MPADD_SUB_EN to build in A-B support.
module ks_mpadd_seq
  import ks_adder_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   cin,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   cout,
  output logic                   busy
);

  localparam int IDX_W = idx_width(WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  ks_state_e              state_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   carry_q;
  logic [WIDTH*WORDS-1:0] a_q;
  logic [WIDTH*WORDS-1:0] b_q;
  logic [WIDTH*WORDS-1:0] sum_q;
  logic                   cout_q;
  logic                   out_valid_q;

  logic [WIDTH-1:0]       a_word_d;
  logic [WIDTH-1:0]       b_word_d;
  logic [WIDTH-1:0]       add_sum_d;
  logic                   add_cout_d;
  logic [WIDTH*WORDS-1:0] b_load_d;
  logic                   carry_load_d;

  assign a_word_d = a_q[int'(idx_q)*WIDTH +: WIDTH];
  assign b_word_d = b_q[int'(idx_q)*WIDTH +: WIDTH];

`ifdef KS_MPADD_SUB_EN
  // Two's-complement subtract: invert B once at accept and inject the +1 as carry.
  assign b_load_d     = sub ? ~b : b;
  assign carry_load_d = sub ? 1'b1 : cin;
`else
  logic unused_sub;
  assign unused_sub   = sub;
  assign b_load_d     = b;
  assign carry_load_d = cin;
`endif

  ks_adder_64 #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a_i    (a_word_d),
    .b_i    (b_word_d),
    .cin_i  (carry_q),
    .sum_o  (add_sum_d),
    .cout_o (add_cout_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b_load_d;
            carry_q <= carry_load_d;
            idx_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q[int'(idx_q)*WIDTH +: WIDTH] <= add_sum_d;
          carry_q <= add_cout_d;
          if (idx_q == IDX_LAST) begin
            cout_q      <= add_cout_d;
            out_valid_q <= 1'b1;
            idx_q       <= '0;
            state_q     <= ST_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
